msix_intr_sched: RTL and testbench

Interrupt scheduler in the QEMU PCIe bridge co-simulation path. It collects per-vector interrupt requests from the virtio device logic and holds them as MSI-X pending bits, honouring per-vector masks. It selects one unmasked pending vector at a time by round-robin and presents it over a valid/ready handshake to the bridge interrupt port, which forwards the vector number to the host through `C_req_interrupt`. A programmable holdoff enforces a minimum spacing between issued interrupts.

---
 rtl/msix_intr_sched.sv | 130 +++++++++++++
 tb/tb_msix_intr_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/msix_intr_sched.sv
// MSI-X interrupt scheduler: pending bits, masks,
// round-robin pick, valid/ready issue, holdoff.
module msix_intr_sched #(
  parameter int NVEC    = 4,
  parameter int VECW    = 2,
  parameter int HOLDOFF = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NVEC-1:0] i_src_req,
  input  logic [NVEC-1:0] i_mask,
  output logic            o_intr_valid,
  output logic [VECW-1:0] o_intr_vector,
  input  logic            i_intr_ready,
  output logic [NVEC-1:0] o_pending,
  output logic            o_busy,
  output logic [15:0]     o_issued_cnt
);

  localparam logic [7:0] HO8 = 8'(HOLDOFF);
  localparam logic [VECW-1:0] LAST = VECW'(NVEC - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } state_t;

  state_t          state;
  logic [NVEC-1:0] src_q;
  logic [NVEC-1:0] mask_q;
  logic [NVEC-1:0] pend;
  logic [NVEC-1:0] edges;
  logic [NVEC-1:0] elig;
  logic [NVEC-1:0] clr;
  logic [VECW-1:0] rr;
  logic [VECW-1:0] win;
  logic [VECW-1:0] iv;
  logic            found;
  logic            accept;
  logic [7:0]      hcnt;
  int              idx;

  assign edges     = i_src_req & ~src_q;
  // Masks are sampled so an unmask takes effect
  // one cycle later, like a new request does.
  assign elig      = pend & ~mask_q;
  assign accept    = o_intr_valid & i_intr_ready;
  assign o_pending = pend;
  assign o_busy    = (state != IDLE);

  // One-hot clear of the vector being accepted.
  always_comb begin
    clr = '0;
    if (accept) clr[o_intr_vector] = 1'b1;
  end

  // Round-robin search from rr upward, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    iv    = '0;
    for (int k = 0; k < NVEC; k++) begin
      idx = (int'(rr) + k) % NVEC;
      iv  = VECW'(idx);
      if (!found && elig[iv]) begin
        found = 1'b1;
        win   = iv;
      end
    end
  end

  // Edge capture, mask sample and pending bits.
  // A new edge wins over a same-cycle clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      src_q  <= '0;
      mask_q <= '0;
      pend   <= '0;
    end else begin
      src_q  <= i_src_req;
      mask_q <= i_mask;
      pend   <= (pend & ~clr) | edges;
    end
  end

  // Issue FSM with registered valid/vector.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      o_intr_valid  <= 1'b0;
      o_intr_vector <= '0;
      o_issued_cnt  <= '0;
      rr            <= '0;
      hcnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            o_intr_vector <= win;
            o_intr_valid  <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_intr_ready) begin
            o_intr_valid <= 1'b0;
            o_issued_cnt <= o_issued_cnt + 16'd1;
            hcnt         <= HO8;
            if (o_intr_vector == LAST) rr <= '0;
            else rr <= o_intr_vector + 1'b1;
            if (HO8 == 8'd0) state <= IDLE;
            else state <= HOLD;
          end
        end
        HOLD: begin
          if (hcnt <= 8'd1) begin
            hcnt  <= 8'd0;
            state <= IDLE;
          end else begin
            hcnt <= hcnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msix_intr_sched.sv
// Directed bench for msix_intr_sched:
// latency, round-robin, masks, holdoff, reset.
module tb_msix_intr_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  src = '0;
  logic [3:0]  mask = '0;
  logic        ready = 1'b1;
  logic        valid;
  logic [1:0]  vec;
  logic [3:0]  pend;
  logic        busy;
  logic [15:0] cnt;

  int   passed = 0;
  int   fails = 0;
  int   total = 0;
  int   cyc_n = 0;
  int   n;
  int   t0;
  int   t1;
  logic ok;

  msix_intr_sched #(
    .NVEC(4),
    .VECW(2),
    .HOLDOFF(16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_src_req(src),
    .i_mask(mask),
    .o_intr_valid(valid),
    .o_intr_vector(vec),
    .i_intr_ready(ready),
    .o_pending(pend),
    .o_busy(busy),
    .o_issued_cnt(cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    src  = '0;
    mask = '0;
    rst  = 1'b1;
    cyc();
    cyc();
    rst  = 1'b0;
  endtask

  task automatic wait_valid(input int maxc,
                            output logic got);
    got = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (valid) begin
        got = 1'b1;
        break;
      end
      cyc();
    end
    if (valid) got = 1'b1;
  endtask

  initial begin
    // reset values
    cyc();
    cyc();
    chk("rst_valid", 32'(valid), 0);
    chk("rst_vec", 32'(vec), 0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(cnt), 0);
    rst = 1'b0;

    // single pulse on vector 2, ready tied high
    ready = 1'b1;
    src = 4'b0100;
    cyc();
    src = 4'b0000;
    chk("t1_pend_set", 32'(pend), 32'h4);
    chk("t1_no_valid_yet", 32'(valid), 0);
    cyc();
    chk("t1_valid", 32'(valid), 1);
    chk("t1_vec", 32'(vec), 2);
    chk("t1_busy", 32'(busy), 1);
    cyc();
    chk("t1_valid_drop", 32'(valid), 0);
    chk("t1_cnt", 32'(cnt), 1);
    chk("t1_pend_clr", 32'(pend), 0);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      n++;
      cyc();
    end
    chk("t1_busy_len", 32'(n), 17);

    // round-robin 0,1,3 with 18-cycle spacing
    do_reset();
    ready = 1'b1;
    src = 4'b1011;
    cyc();
    src = 4'b0000;
    wait_valid(5, ok);
    chk("t2_got0", 32'(ok), 1);
    chk("t2_vec0", 32'(vec), 0);
    cyc();
    t0 = cyc_n;
    wait_valid(30, ok);
    chk("t2_vec1", 32'(vec), 1);
    cyc();
    t1 = cyc_n;
    chk("t2_gap01", 32'(t1 - t0), 18);
    t0 = t1;
    wait_valid(30, ok);
    chk("t2_vec3", 32'(vec), 3);
    cyc();
    t1 = cyc_n;
    chk("t2_gap13", 32'(t1 - t0), 18);
    src = 4'b0011;
    cyc();
    src = 4'b0000;
    wait_valid(30, ok);
    chk("t2_wrap_got", 32'(ok), 1);
    chk("t2_wrap_vec0", 32'(vec), 0);
    cyc();
    wait_valid(30, ok);
    chk("t2_then_vec1", 32'(vec), 1);
    cyc();
    chk("t2_cnt", 32'(cnt), 5);

    // masked request held, issued after unmask
    do_reset();
    mask = 4'b0010;
    src = 4'b0010;
    cyc();
    src = 4'b0000;
    repeat (6) cyc();
    chk("t3_masked_novalid", 32'(valid), 0);
    chk("t3_masked_pend", 32'(pend), 32'h2);
    mask = 4'b0000;
    wait_valid(4, ok);
    chk("t3_unmask_got", 32'(ok), 1);
    chk("t3_unmask_vec", 32'(vec), 1);
    cyc();

    // offer held while ready low, mask mid-wait
    do_reset();
    ready = 1'b0;
    src = 4'b0100;
    cyc();
    src = 4'b0000;
    cyc();
    chk("t4_valid", 32'(valid), 1);
    chk("t4_vec", 32'(vec), 2);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) mask = 4'b0100;
      cyc();
      chk("t4_hold", 32'({valid, vec}), 32'h6);
    end
    chk("t4_cnt0", 32'(cnt), 0);
    ready = 1'b1;
    cyc();
    chk("t4_acc_valid", 32'(valid), 0);
    chk("t4_acc_cnt", 32'(cnt), 1);
    chk("t4_acc_pend", 32'(pend), 0);
    mask = 4'b0000;

    // new edge on the accept cycle keeps bit set
    do_reset();
    ready = 1'b0;
    src = 4'b0100;
    cyc();
    src = 4'b0000;
    cyc();
    chk("t5_valid", 32'(valid), 1);
    ready = 1'b1;
    src = 4'b0100;
    cyc();
    src = 4'b0000;
    chk("t5_acc_valid", 32'(valid), 0);
    chk("t5_pend_kept", 32'(pend), 32'h4);
    chk("t5_cnt1", 32'(cnt), 1);
    wait_valid(30, ok);
    chk("t5_reissue_got", 32'(ok), 1);
    chk("t5_reissue_vec", 32'(vec), 2);
    cyc();
    chk("t5_cnt2", 32'(cnt), 2);
    chk("t5_pend_clr", 32'(pend), 0);

    // async reset during ISSUE
    do_reset();
    ready = 1'b0;
    src = 4'b0100;
    cyc();
    src = 4'b0000;
    cyc();
    chk("t6_valid", 32'(valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(valid), 0);
    chk("t6_async_pend", 32'(pend), 0);
    chk("t6_async_busy", 32'(busy), 0);
    cyc();
    rst = 1'b0;
    ready = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (valid) n++;
    end
    chk("t6_no_issue", 32'(n), 0);
    chk("t6_cnt", 32'(cnt), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
